// File: rtl/data_collect_ctrl_if.sv
// Handshake and RAM-control bundle between the data-collection sequencer and its surroundings.
// master = the system side (commands, sample source, playback sink); slave = the sequencer.
interface data_collect_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              start_capture;
  logic              stop_capture;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              start_playback;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              play_done;
  logic [ADDR_W-1:0] count;
  logic              full;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_out_en;
  logic              mem_active;
  logic              mem_rw;

  modport master (
    output start_capture, stop_capture, sample_in, sample_valid, start_playback, out_ready,
    input  sample_ready, out_data, out_valid, play_done, count, full, busy,
    input  mem_address, mem_out_en, mem_active, mem_rw
  );

  modport slave (
    input  start_capture, stop_capture, sample_in, sample_valid, start_playback, out_ready,
    output sample_ready, out_data, out_valid, play_done, count, full, busy,
    output mem_address, mem_out_en, mem_active, mem_rw
  );
endinterface

// File: rtl/data_collect_ctrl.sv
// Capture/playback sequencer for the 750 x 8 data-collection RAM.
// Owns all RAM control pins and the controller side of the shared data bus.
//
// state      | meaning
// S_IDLE     | waiting for start_capture / start_playback
// S_CAP_WAIT | capture armed, waiting for a sample or stop
// S_CAP_WR   | writing the latched sample at wr_ptr
// S_PB_RD1   | RAM latches stored[rd_ptr] into its MDR
// S_PB_RD2   | RAM drives the bus, sample registered to out_data
// S_PB_OUT   | holding out_data until out_ready
module data_collect_ctrl #(
  parameter int DEPTH  = 750,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  data_collect_ctrl_if.slave bus,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP_WAIT,
    S_CAP_WR,
    S_PB_RD1,
    S_PB_RD2,
    S_PB_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] L_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(DEPTH);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_play_done;

  logic              w_mem_active;
  logic              w_mem_out_en;
  logic              w_mem_rw;
  logic [ADDR_W-1:0] w_mem_address;
  logic              w_sample_ready;

  assign w_sample_ready = (r_state == S_CAP_WAIT) && !bus.stop_capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wdata     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_play_done <= 1'b0;
    end else begin
      r_play_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_capture) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_state  <= S_CAP_WAIT;
          end else if (bus.start_playback) begin
            if (r_count != '0) begin
              r_rd_ptr <= '0;
              r_state  <= S_PB_RD1;
            end else begin
              r_play_done <= 1'b1;
            end
          end
        end
        // stop wins over a simultaneous sample: that sample is dropped
        S_CAP_WAIT: begin
          if (bus.stop_capture) begin
            r_state <= S_IDLE;
          end else if (bus.sample_valid) begin
            r_wdata <= bus.sample_in;
            r_state <= S_CAP_WR;
          end
        end
        S_CAP_WR: begin
          r_wr_ptr <= r_wr_ptr + L_ONE;
          r_count  <= r_count + L_ONE;
          r_state  <= (r_count == L_LAST) ? S_IDLE : S_CAP_WAIT;
        end
        S_PB_RD1: begin
          r_state <= S_PB_RD2;
        end
        S_PB_RD2: begin
          r_out_data  <= mem_data;
          r_out_valid <= 1'b1;
          r_state     <= S_PB_OUT;
        end
        S_PB_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_rd_ptr == r_count - L_ONE) begin
              r_play_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_rd_ptr <= r_rd_ptr + L_ONE;
              r_state  <= S_PB_RD1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM pins decode purely from the registered state, so the bus driver
  // and the RAM read window can never overlap
  always_comb begin
    w_mem_active  = 1'b0;
    w_mem_out_en  = 1'b0;
    w_mem_rw      = 1'b1;
    w_mem_address = '0;
    case (r_state)
      S_CAP_WR: begin
        w_mem_active  = 1'b1;
        w_mem_out_en  = 1'b1;
        w_mem_rw      = 1'b0;
        w_mem_address = r_wr_ptr;
      end
      S_PB_RD1, S_PB_RD2: begin
        w_mem_active  = 1'b1;
        w_mem_address = r_rd_ptr;
      end
      default: ;
    endcase
  end

  assign mem_data = w_mem_out_en ? r_wdata : {DATA_W{1'bz}};

  assign bus.sample_ready = w_sample_ready;
  assign bus.out_data     = r_out_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.play_done    = r_play_done;
  assign bus.count        = r_count;
  assign bus.full         = (r_count == L_DEPTH);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.mem_address  = w_mem_address;
  assign bus.mem_out_en   = w_mem_out_en;
  assign bus.mem_active   = w_mem_active;
  assign bus.mem_rw       = w_mem_rw;

endmodule

// File: tb/tb_data_collect_ctrl.sv
// Bench for data_collect_ctrl: cycle-by-cycle vector table for capture/playback,
// plus sequences for fill-to-full and reset during a RAM read.
module tb_data_collect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  wire  [7:0] mem_data;

  always #5 clk = ~clk;

  data_collect_ctrl_if #(.ADDR_W(10), .DATA_W(8)) ifc ();

  data_collect_ctrl #(.DEPTH(750), .ADDR_W(10), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifc),
    .mem_data (mem_data)
  );

  // RAM model: latch into MDR on a read cycle, drive MDR while in read mode
  logic [7:0] ram [0:749];
  logic [7:0] mdr = 8'h00;
  logic       ram_drv;
  assign ram_drv  = ifc.mem_active && ifc.mem_rw;
  assign mem_data = ram_drv ? mdr : 8'bz;

  always @(posedge clk) begin
    if (ifc.mem_active) begin
      if (ifc.mem_rw) mdr <= ram[ifc.mem_address];
      else            ram[ifc.mem_address] <= mem_data;
    end
  end

  int contention = 0;
  always @(negedge clk) if (ifc.mem_out_en && ram_drv) contention++;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int sc, stp, sv, sin, sp, ordy;
    int rdy, bsy, oe, act, addr, cnt, ov, od, pd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int sc, input int stp, input int sv, input int sin,
                              input int sp, input int ordy, input int rdy, input int bsy,
                              input int oe, input int act, input int addr, input int cnt,
                              input int ov, input int od, input int pd);
    vec_t v;
    v.sc = sc; v.stp = stp; v.sv = sv; v.sin = sin; v.sp = sp; v.ordy = ordy;
    v.rdy = rdy; v.bsy = bsy; v.oe = oe; v.act = act; v.addr = addr; v.cnt = cnt;
    v.ov = ov; v.od = od; v.pd = pd;
    tbl.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit timed_out;
    int bad;

    for (int i = 0; i < 750; i++) ram[i] = 8'hAA;
    reset              = 1'b1;
    ifc.start_capture  = 1'b0;
    ifc.stop_capture   = 1'b0;
    ifc.sample_in      = 8'h00;
    ifc.sample_valid   = 1'b0;
    ifc.start_playback = 1'b0;
    ifc.out_ready      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset out_valid", ifc.out_valid, 0);
    chk("reset count", ifc.count, 0);
    chk("reset busy", ifc.busy, 0);
    chk("reset mem_active", ifc.mem_active, 0);
    chk("reset mem_rw", ifc.mem_rw, 1);
    chk("reset mem_out_en", ifc.mem_out_en, 0);
    chk("reset full", ifc.full, 0);

    //   sc stp sv sin sp ordy | rdy bsy oe act addr cnt ov od pd
    add(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0); // playback with count 0
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1); // immediate play_done, no RAM access
    add(1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0); // both starts: capture wins
    add(0, 0, 1, 3, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0); // CAP_WAIT
    add(0, 0, 1, 5, 0, 0,   0, 1, 1, 1, 0, 0, 0, 0, 0); // CAP_WR 3 @0
    add(0, 0, 1, 5, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 2, 0, 0,   0, 1, 1, 1, 1, 1, 0, 0, 0); // CAP_WR 5 @1
    add(0, 0, 1, 2, 0, 0,   1, 1, 0, 0, 0, 2, 0, 0, 0);
    add(0, 1, 1, 9, 0, 0,   0, 1, 1, 1, 2, 2, 0, 0, 0); // CAP_WR 2 @2, stop ignored
    add(0, 1, 1, 9, 0, 0,   0, 1, 0, 0, 0, 3, 0, 0, 0); // stop + valid: 9 dropped
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 3, 0, 0, 0); // start playback
    add(1, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, 3, 0, 0, 0); // RD1, capture start ignored
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, 3, 0, 0, 0); // RD2
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 3, 1, 3, 0); // OUT 3, third cycle after start
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 1, 3, 0, 3, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 1, 3, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 3, 1, 5, 0); // backpressure x5
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 3, 1, 5, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 3, 1, 5, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 3, 1, 5, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 3, 1, 5, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 3, 1, 5, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 2, 3, 0, 5, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 2, 3, 0, 5, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 3, 1, 2, 0); // OUT 2, last
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0, 2, 1); // play_done
    add(0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 3, 0, 2, 0); // second playback, no stalls
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, 3, 0, 2, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, 3, 0, 2, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 3, 1, 3, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 1, 3, 0, 3, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 1, 3, 0, 3, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 3, 1, 5, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 2, 3, 0, 5, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 2, 3, 0, 5, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 3, 1, 2, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0, 2, 1);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0, 2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      @(negedge clk);
      ifc.start_capture  = v.sc[0];
      ifc.stop_capture   = v.stp[0];
      ifc.sample_valid   = v.sv[0];
      ifc.sample_in      = v.sin[7:0];
      ifc.start_playback = v.sp[0];
      ifc.out_ready      = v.ordy[0];
      #1;
      chk($sformatf("row%0d sample_ready", i), ifc.sample_ready, v.rdy);
      chk($sformatf("row%0d busy", i), ifc.busy, v.bsy);
      chk($sformatf("row%0d mem_out_en", i), ifc.mem_out_en, v.oe);
      chk($sformatf("row%0d mem_rw", i), ifc.mem_rw, (v.oe != 0) ? 0 : 1);
      chk($sformatf("row%0d mem_active", i), ifc.mem_active, v.act);
      chk($sformatf("row%0d mem_address", i), ifc.mem_address, v.addr);
      chk($sformatf("row%0d count", i), ifc.count, v.cnt);
      chk($sformatf("row%0d full", i), ifc.full, 0);
      chk($sformatf("row%0d out_valid", i), ifc.out_valid, v.ov);
      chk($sformatf("row%0d out_data", i), ifc.out_data, v.od);
      chk($sformatf("row%0d play_done", i), ifc.play_done, v.pd);
    end

    chk("ram[0]", ram[0], 3);
    chk("ram[1]", ram[1], 5);
    chk("ram[2]", ram[2], 2);
    chk("ram[3] untouched by stop-cycle sample", ram[3], 8'hAA);

    // fill to DEPTH with value i mod 256
    @(negedge clk);
    ifc.start_capture = 1'b1;
    @(negedge clk);
    ifc.start_capture = 1'b0;
    timed_out = 1'b0;
    for (int i = 0; i < 750 && !timed_out; i++) begin
      int guard;
      ifc.sample_in    = i[7:0];
      ifc.sample_valid = 1'b1;
      #1;
      guard = 0;
      while (!ifc.sample_ready && !timed_out) begin
        if (guard == 4) begin
          timed_out = 1'b1;
          chk($sformatf("fill handshake timeout at sample %0d", i), 0, 1);
        end else begin
          @(negedge clk);
          #1;
          guard++;
        end
      end
      @(negedge clk);
    end
    ifc.sample_in = 8'hEE;
    @(negedge clk);
    #1;
    chk("fill full", ifc.full, 1);
    chk("fill count", ifc.count, 750);
    chk("fill auto idle", ifc.busy, 0);
    chk("fill 751st sample_ready", ifc.sample_ready, 0);
    @(negedge clk);
    #1;
    chk("fill count stays", ifc.count, 750);
    chk("fill 751st sample_ready later", ifc.sample_ready, 0);
    ifc.sample_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 750; i++) if (ram[i] != i[7:0]) bad++;
    chk("fill ram content mismatches", bad, 0);

    // reset while the RAM drives the bus (PB_RD2)
    @(negedge clk);
    ifc.start_playback = 1'b1;
    ifc.out_ready      = 1'b1;
    @(negedge clk);
    ifc.start_playback = 1'b0;
    #1;
    chk("pb rd1 mem_active", ifc.mem_active, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("pb rd2 mem_active", ifc.mem_active, 1);
    chk("pb rd2 mem_out_en", ifc.mem_out_en, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset in rd2 busy", ifc.busy, 0);
    chk("reset in rd2 out_valid", ifc.out_valid, 0);
    chk("reset in rd2 out_data", ifc.out_data, 0);
    chk("reset in rd2 count", ifc.count, 0);
    chk("reset in rd2 mem_active", ifc.mem_active, 0);
    @(negedge clk);
    #1;
    chk("after reset out_valid stays low", ifc.out_valid, 0);

    chk("bus contention cycles", contention, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
